// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP-slice dot-product sequencer.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } seq_state_e;

  localparam logic [7:0] OpmodeRst  = 8'h00;
  localparam logic [7:0] OpmodeLoad = 8'h01;  // P = M
  localparam logic [7:0] OpmodeHold = 8'h08;  // P = P
  localparam logic [7:0] OpmodeAcc  = 8'h09;  // P = P + M

  // A1REG -> MREG -> PREG
  localparam int unsigned PipeDepth = 3;
  localparam int unsigned DrainW    = 2;

  function automatic logic [7:0] tag_opmode(input logic valid, input logic first);
    if (!valid) return OpmodeHold;
    return first ? OpmodeLoad : OpmodeAcc;
  endfunction

endpackage

// File: rtl/dsp_seq_tag_pipe.sv
// One-cycle delay of the operand valid/first tag, turned into the slice OPMODE.
module dsp_seq_tag_pipe
  import dsp_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic       first_i,
  output logic [7:0] opmode_o
);

  logic [7:0] opmode_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opmode_q <= OpmodeRst;
    end else begin
      opmode_q <= tag_opmode(valid_i, first_i);
    end
  end

  assign opmode_o = opmode_q;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Feeds operand pairs into an external pipelined DSP slice and collects the dot product.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      a_in,
  input  logic [17:0]      b_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      result,
  output logic             busy,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  input  logic [47:0]      dsp_p
);

  seq_state_e        state_q, state_d;
  logic [LEN_W:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [47:0]       result_q, result_d;
  logic [17:0]       a_q, b_q;
  logic              tag_valid_q, tag_first_q;
  logic              load_open, xfer;

  assign load_open = (state_q == StLoad) && (cnt_q != {1'b0, len_q});
  assign xfer      = in_valid && load_open;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    drain_d  = drain_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d = len;
          cnt_d = '0;
          if (len == '0) begin
            result_d = '0;
            state_d  = StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (xfer) cnt_d = cnt_q + {{LEN_W{1'b0}}, 1'b1};
        // Count already reached len: last product is still in flight.
        if (!load_open) begin
          drain_d = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_q == DrainW'(PipeDepth - 1)) begin
          result_d = dsp_p;
          state_d  = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      drain_q     <= '0;
      result_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_valid_q <= 1'b0;
      tag_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      drain_q     <= drain_d;
      result_q    <= result_d;
      tag_valid_q <= xfer;
      tag_first_q <= xfer && (cnt_q == '0);
      if (xfer) begin
        a_q <= a_in;
        b_q <= b_in;
      end
    end
  end

  dsp_seq_tag_pipe u_tag_pipe (
    .clk_i    (CLK),
    .rst_i    (RST),
    .valid_i  (tag_valid_q),
    .first_i  (tag_first_q),
    .opmode_o (dsp_opmode)
  );

  assign in_ready  = load_open;
  assign res_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign dsp_ce    = busy;
  assign result    = result_q;
  assign dsp_a     = a_q;
  assign dsp_b     = b_q;

endmodule
